// File: rtl/prediction_stat_tracker_pkg.sv
// prediction_stat_tracker_pkg: trend encodings, counter steps and trend decoder shared by the tracker.
package prediction_stat_tracker_pkg;
  localparam logic [3:0] TREND_MISS2 = 4'b0001;
  localparam logic [3:0] TREND_MIX01 = 4'b0010;
  localparam logic [3:0] TREND_MIX10 = 4'b0100;
  localparam logic [3:0] TREND_HIT2  = 4'b1000;
  localparam int STAT_INC = 1;
  localparam int STAT_DEC = 2;
  function automatic logic [3:0] decode_trend(input logic [1:0] h);
    return h == 2'b00 ? TREND_MISS2 : h == 2'b01 ? TREND_MIX01 : h == 2'b10 ? TREND_MIX10 : TREND_HIT2;
  endfunction
endpackage

// File: rtl/prediction_stat_tracker_stat_trend_unit.sv
// stat_trend_unit: one predictor's saturating confidence counter and two-deep hit/miss history.
module stat_trend_unit
  import prediction_stat_tracker_pkg::*;
#(
  parameter int STAT_COUNTER_WIDTH = 5,
  parameter int STAT_INIT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic correct,
  output logic [STAT_COUNTER_WIDTH-1:0] count,
  output logic [3:0] trend_decode
);
  localparam int W = STAT_COUNTER_WIDTH;
  localparam logic [W-1:0] MAX = '1;
  logic [1:0] hist;
  logic [W-1:0] next_count;
  always_comb
    next_count = correct ? (count == MAX ? MAX : count + W'(STAT_INC))
                         : (count < W'(STAT_DEC) ? '0 : count - W'(STAT_DEC));
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= W'(STAT_INIT);
      hist  <= 2'b01;
    end else if (en) begin
      count <= next_count;
      hist  <= {hist[0], correct};
    end
  end
  assign trend_decode = decode_trend(hist);
endmodule

// File: rtl/prediction_stat_tracker.sv
// prediction_stat_tracker: queues component predictions and scores them at resolve into stat counters and trends.
module prediction_stat_tracker
  import prediction_stat_tracker_pkg::*;
#(
  parameter int STAT_COUNTER_WIDTH = 5,
  parameter int QUEUE_DEPTH = 4,
  parameter int STAT_INIT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic predict_valid,
  output logic predict_ready,
  input  logic SP_prediction,
  input  logic LHP_prediction,
  input  logic GHP_prediction,
  input  logic resolve_valid,
  input  logic resolve_taken,
  input  logic flush,
  output logic [STAT_COUNTER_WIDTH-1:0] SP_stat_count,
  output logic [STAT_COUNTER_WIDTH-1:0] LHP_stat_count,
  output logic [STAT_COUNTER_WIDTH-1:0] GHP_stat_count,
  output logic [3:0] SP_trend_decode,
  output logic [3:0] LHP_trend_decode,
  output logic [3:0] GHP_trend_decode,
  output logic [$clog2(QUEUE_DEPTH):0] pending_count,
  output logic resolve_underflow
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  logic [2:0] mem [QUEUE_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic empty, full, push, pop;
  logic [2:0] head;
  assign empty = pending_count == '0;
  assign full = pending_count == (AW+1)'(QUEUE_DEPTH);
  assign pop = resolve_valid && !empty;
  // a pop frees the slot a same-cycle push needs, so a full queue still accepts it
  assign push = predict_valid && !flush && (!full || pop);
  assign predict_ready = !full;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      pending_count <= '0;
      resolve_underflow <= 1'b0;
    end else begin
      resolve_underflow <= resolve_valid && empty;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        pending_count <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        pending_count <= pending_count + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  end
  always_ff @(posedge clk)
    if (push && !rst) mem[wr_ptr] <= {SP_prediction, LHP_prediction, GHP_prediction};
  stat_trend_unit #(.STAT_COUNTER_WIDTH(STAT_COUNTER_WIDTH), .STAT_INIT(STAT_INIT)) u_sp (
    .clk(clk), .rst(rst), .en(pop), .correct(head[2] == resolve_taken),
    .count(SP_stat_count), .trend_decode(SP_trend_decode));
  stat_trend_unit #(.STAT_COUNTER_WIDTH(STAT_COUNTER_WIDTH), .STAT_INIT(STAT_INIT)) u_lhp (
    .clk(clk), .rst(rst), .en(pop), .correct(head[1] == resolve_taken),
    .count(LHP_stat_count), .trend_decode(LHP_trend_decode));
  stat_trend_unit #(.STAT_COUNTER_WIDTH(STAT_COUNTER_WIDTH), .STAT_INIT(STAT_INIT)) u_ghp (
    .clk(clk), .rst(rst), .en(pop), .correct(head[0] == resolve_taken),
    .count(GHP_stat_count), .trend_decode(GHP_trend_decode));
endmodule

// File: tb/tb_prediction_stat_tracker.sv
// tb_prediction_stat_tracker: directed and random stimulus against a queue-based behavioural model.
module tb_prediction_stat_tracker;
  localparam int W = 5;
  localparam int D = 4;
  localparam int MAXC = (1 << W) - 1;
  logic clk = 0, rst = 1;
  logic predict_valid = 0, predict_ready;
  logic SP_prediction = 0, LHP_prediction = 0, GHP_prediction = 0;
  logic resolve_valid = 0, resolve_taken = 0, flush = 0;
  logic [W-1:0] SP_stat_count, LHP_stat_count, GHP_stat_count;
  logic [3:0] SP_trend_decode, LHP_trend_decode, GHP_trend_decode;
  logic [$clog2(D):0] pending_count;
  logic resolve_underflow;
  int checks = 0, failures = 0;
  logic [2:0] mq [$];
  int mc [3];
  int mh [3];
  int muf;

  prediction_stat_tracker #(.STAT_COUNTER_WIDTH(W), .QUEUE_DEPTH(D), .STAT_INIT(0)) dut (
    .clk(clk), .rst(rst), .predict_valid(predict_valid), .predict_ready(predict_ready),
    .SP_prediction(SP_prediction), .LHP_prediction(LHP_prediction), .GHP_prediction(GHP_prediction),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .flush(flush),
    .SP_stat_count(SP_stat_count), .LHP_stat_count(LHP_stat_count), .GHP_stat_count(GHP_stat_count),
    .SP_trend_decode(SP_trend_decode), .LHP_trend_decode(LHP_trend_decode), .GHP_trend_decode(GHP_trend_decode),
    .pending_count(pending_count), .resolve_underflow(resolve_underflow));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic pv, input logic [2:0] g, input logic rv, input logic rt,
                      input logic fl, input logic r);
    int n;
    logic [2:0] e;
    int gc [3];
    int gt [3];
    predict_valid = pv;
    {SP_prediction, LHP_prediction, GHP_prediction} = g;
    resolve_valid = rv;
    resolve_taken = rt;
    flush = fl;
    rst = r;
    @(posedge clk);
    n = mq.size();
    if (r) begin
      mq.delete();
      muf = 0;
      for (int i = 0; i < 3; i++) begin mc[i] = 0; mh[i] = 1; end
    end else begin
      muf = (rv && n == 0) ? 1 : 0;
      if (rv && n > 0) begin
        e = mq.pop_front();
        for (int i = 0; i < 3; i++) begin
          int c;
          c = (e[2-i] == rt) ? 1 : 0;
          mc[i] = c ? (mc[i] + 1 > MAXC ? MAXC : mc[i] + 1) : (mc[i] - 2 < 0 ? 0 : mc[i] - 2);
          mh[i] = (mh[i] * 2 + c) % 4;
        end
      end
      if (pv && !fl && (n < D || (rv && n > 0))) mq.push_back(g);
      if (fl) mq.delete();
    end
    #1;
    gc[0] = SP_stat_count; gc[1] = LHP_stat_count; gc[2] = GHP_stat_count;
    gt[0] = SP_trend_decode; gt[1] = LHP_trend_decode; gt[2] = GHP_trend_decode;
    chk("pending_count", pending_count, mq.size());
    chk("predict_ready", predict_ready, mq.size() < D);
    chk("underflow", resolve_underflow, muf);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("count%0d", i), gc[i], mc[i]);
      chk($sformatf("trend%0d", i), gt[i], 1 << mh[i]);
    end
  endtask

  initial begin
    step(0, 0, 0, 0, 0, 1);
    chk("reset_trend", SP_trend_decode, 4'b0010);
    chk("reset_ready", predict_ready, 1);
    for (int i = 0; i < 3; i++) step(1, 3'b111, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    chk("hit2_trend", SP_trend_decode, 4'b1000);
    step(0, 0, 1, 1, 0, 0);
    chk("three_hits", GHP_stat_count, 3);
    for (int i = 0; i < 2; i++) step(1, 3'b101, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 1, 1, 0, 0);
    chk("sp_after_mix", SP_stat_count, 5);
    chk("lhp_floor", LHP_stat_count, 0);
    chk("lhp_miss2", LHP_trend_decode, 4'b0001);
    for (int i = 0; i < 40; i++) step(1, 3'b111, 1, 1, 0, 0);
    chk("saturate", SP_stat_count, MAXC);
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 3'($urandom), 0, 0, 0, 0);
    chk("full_ready", predict_ready, 0);
    step(1, 3'b111, 0, 0, 0, 0);
    chk("full_drop", pending_count, D);
    for (int i = 0; i < 10; i++) begin
      step(1, 3'($urandom), 1, 1'($urandom), 0, 0);
      chk("full_pushpop", pending_count, D);
    end
    step(0, 0, 0, 0, 0, 1);
    step(1, 3'b010, 1, 1, 0, 0);
    chk("underflow_pulse", resolve_underflow, 1);
    chk("underflow_push", pending_count, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("underflow_once", resolve_underflow, 0);
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 3'b110, 0, 0, 0, 0);
    step(1, 3'b111, 1, 1, 1, 0);
    chk("flush_empty", pending_count, 0);
    chk("flush_scored", SP_stat_count, 1);
    step(1, 3'b001, 0, 0, 0, 0);
    step(1, 3'b001, 0, 0, 0, 0);
    step(1, 3'b001, 1, 0, 0, 1);
    chk("rst_mid", pending_count, 0);
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 2) != 0), 3'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom),
           $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
